// File: rtl/li_adder_pkg.sv
// rtl/li_adder_pkg.sv - shared states, default widths and helpers for the adder driver
package li_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } drv_state_e;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_ACC_W      = 48;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_MAX_OUT    = 2;
  localparam int DEF_CNT_W      = 16;

  // Pointer width that stays legal for a single-entry FIFO.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/li_sync_fifo.sv
// rtl/li_sync_fifo.sv - single-clock FIFO with occupancy count; push and pop may coincide when full
module li_sync_fifo
  import li_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = ptr_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem[rd_ptr];
  assign do_pop   = pop && !empty;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);

  // Storage write; contents need no reset since occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/li_adder_driver.sv
// rtl/li_adder_driver.sv - operand buffer, request issue, response accumulate; result self-check under LI_ADDER_CHECK_EN
module li_adder_driver
  import li_adder_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int MAX_OUT    = DEF_MAX_OUT,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic              enable,
  input  logic              rsp_stall,
  output logic [DATA_W-1:0] req_a,
  output logic [DATA_W-1:0] req_b,
  output logic              req_valid,
  input  logic              req_ready,
  input  logic [DATA_W-1:0] rsp_sum,
  input  logic              rsp_valid,
  output logic              rsp_ready,
  output logic [ACC_W-1:0]  acc_total,
  output logic [CNT_W-1:0]  issued_cnt,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic              idle,
  output logic              drain_done,
  output logic              proto_err,
  output logic              chk_err
);

  localparam int OUT_W = $clog2(MAX_OUT + 2);
  localparam int FCW   = $clog2(FIFO_DEPTH + 1);

  drv_state_e state_q, state_d;

  logic [2*DATA_W-1:0] op_head;
  logic                op_full;
  logic                op_empty;
  logic [FCW-1:0]      op_count;

  logic                req_valid_q;
  logic [DATA_W-1:0]   req_a_q, req_b_q;
  logic [OUT_W-1:0]    outstanding_q;
  logic [OUT_W-1:0]    in_flight;
  logic [ACC_W-1:0]    acc_q;
  logic [CNT_W-1:0]    issued_q, retired_q;
  logic                proto_err_q;

  logic                op_push, load;
  logic                req_xfer, rsp_xfer, rsp_accept, rsp_spur;
  logic                drain_done_c;
  logic                unused_ok;

  assign op_ready   = rst_n && !op_full;
  assign op_push    = op_valid && op_ready;
  assign rsp_ready  = rst_n && !rsp_stall;
  assign req_xfer   = req_valid_q && req_ready;
  assign rsp_xfer   = rsp_valid && rsp_ready;
  assign rsp_accept = rsp_xfer && (outstanding_q != '0);
  assign rsp_spur   = rsp_xfer && (outstanding_q == '0);

  // The held request counts against the window so the adder never sees more than MAX_OUT.
  assign in_flight  = outstanding_q + OUT_W'(req_valid_q);
  assign load       = (state_q == ST_ACTIVE) && !op_empty &&
                      (!req_valid_q || req_xfer) && (in_flight < OUT_W'(MAX_OUT));

  li_sync_fifo #(
    .WIDTH (2*DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_op_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (op_push),
    .push_data ({op_a, op_b}),
    .pop       (load),
    .pop_data  (op_head),
    .full      (op_full),
    .empty     (op_empty),
    .count     (op_count)
  );

`ifdef LI_ADDER_CHECK_EN
  logic [DATA_W-1:0]            exp_head;
  logic                         exp_full;
  logic                         exp_empty;
  logic [$clog2(MAX_OUT+1)-1:0] exp_count;
  logic                         chk_err_q;

  li_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (MAX_OUT)
  ) u_exp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (load),
    .push_data (op_head[2*DATA_W-1:DATA_W] + op_head[DATA_W-1:0]),
    .pop       (rsp_accept),
    .pop_data  (exp_head),
    .full      (exp_full),
    .empty     (exp_empty),
    .count     (exp_count)
  );

  // Sticky flag for any retired sum that differs from what was issued.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chk_err_q <= 1'b0;
    end else if (rsp_accept && !exp_empty && (rsp_sum != exp_head)) begin
      chk_err_q <= 1'b1;
    end
  end

  assign chk_err   = chk_err_q;
  assign unused_ok = ^{op_count, exp_full, exp_count};
`else
  assign chk_err   = 1'b0;
  assign unused_ok = ^{op_count};
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; DRAIN completes only once nothing is held or awaited.
  always_comb begin
    state_d      = state_q;
    drain_done_c = 1'b0;
    case (state_q)
      ST_IDLE:   if (enable)  state_d = ST_ACTIVE;
      ST_ACTIVE: if (!enable) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!req_valid_q && (outstanding_q == '0)) begin
          state_d      = ST_IDLE;
          drain_done_c = 1'b1;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // Request holding register: loaded from the FIFO head, held until accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_valid_q <= 1'b0;
      req_a_q     <= '0;
      req_b_q     <= '0;
    end else if (load) begin
      req_valid_q <= 1'b1;
      req_a_q     <= op_head[2*DATA_W-1:DATA_W];
      req_b_q     <= op_head[DATA_W-1:0];
    end else if (req_xfer) begin
      req_valid_q <= 1'b0;
    end
  end

  // Outstanding tracking, accumulation, counters and protocol error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outstanding_q <= '0;
      acc_q         <= '0;
      issued_q      <= '0;
      retired_q     <= '0;
      proto_err_q   <= 1'b0;
    end else begin
      case ({req_xfer, rsp_accept})
        2'b10:   outstanding_q <= outstanding_q + OUT_W'(1);
        2'b01:   outstanding_q <= outstanding_q - OUT_W'(1);
        default: outstanding_q <= outstanding_q;
      endcase
      if (req_xfer) issued_q <= issued_q + CNT_W'(1);
      if (rsp_accept) begin
        acc_q     <= acc_q + ACC_W'(rsp_sum);
        retired_q <= retired_q + CNT_W'(1);
      end
      if (rsp_spur) proto_err_q <= 1'b1;
    end
  end

  assign req_valid   = req_valid_q;
  assign req_a       = req_a_q;
  assign req_b       = req_b_q;
  assign acc_total   = acc_q;
  assign issued_cnt  = issued_q;
  assign retired_cnt = retired_q;
  assign proto_err   = proto_err_q;
  assign idle        = (state_q == ST_IDLE);
  assign drain_done  = drain_done_c;

endmodule

// File: tb/tb_li_adder_driver.sv
// tb/tb_li_adder_driver.sv - scoreboard bench for li_adder_driver with a behavioural adder
module tb_li_adder_driver;

  localparam int ACC_W = 34;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] op_a, op_b;
  logic        op_valid, op_ready, enable, rsp_stall;
  logic [31:0] req_a, req_b;
  logic        req_valid, req_ready;
  logic [31:0] rsp_sum;
  logic        rsp_valid, rsp_ready;
  logic [ACC_W-1:0] acc_total;
  logic [15:0] issued_cnt, retired_cnt;
  logic        idle, drain_done, proto_err, chk_err;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q[$];
  logic [31:0] rq[$];
  logic        acc_en = 1'b1;
  logic        plus1 = 1'b0;
  logic        inject = 1'b0;
  logic [31:0] inject_val = 32'h0;
  logic        s_req_xfer = 1'b0, s_rsp_xfer = 1'b0;
  logic [31:0] s_a = 32'h0, s_b = 32'h0;

  li_adder_driver #(.ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .op_a(op_a), .op_b(op_b), .op_valid(op_valid),
    .op_ready(op_ready), .enable(enable), .rsp_stall(rsp_stall), .req_a(req_a),
    .req_b(req_b), .req_valid(req_valid), .req_ready(req_ready), .rsp_sum(rsp_sum),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .acc_total(acc_total),
    .issued_cnt(issued_cnt), .retired_cnt(retired_cnt), .idle(idle),
    .drain_done(drain_done), .proto_err(proto_err), .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every request transfer must match the next queued operand pair.
  always @(negedge clk) begin
    if (rst_n && req_valid && req_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL req_unexpected: got a=0x%0h b=0x%0h expected no request", req_a, req_b);
      end else begin
        check("req_operands", {req_a, req_b}, exp_q.pop_front());
      end
    end
  end

  // Capture what will transfer at the coming edge; inputs only move just after posedge.
  always @(negedge clk) begin
    s_req_xfer = rst_n && req_valid && req_ready;
    s_rsp_xfer = rst_n && rsp_valid && rsp_ready;
    s_a = req_a;
    s_b = req_b;
  end

  // Behavioural adder: one-cycle latency, in-order results, optional +1 corruption.
  always @(posedge clk) begin
    logic [31:0] tmp;
    #1;
    if (!rst_n) begin
      rq.delete();
      inject = 1'b0;
    end else begin
      if (s_rsp_xfer) begin
        if (rq.size() > 0) tmp = rq.pop_front();
        else inject = 1'b0;
      end
      if (s_req_xfer) rq.push_back(s_a + s_b + {31'b0, plus1});
    end
    req_ready = acc_en;
    if (rq.size() > 0) begin
      rsp_valid = 1'b1;
      rsp_sum   = rq[0];
    end else if (inject) begin
      rsp_valid = 1'b1;
      rsp_sum   = inject_val;
    end else begin
      rsp_valid = 1'b0;
      rsp_sum   = 32'h0;
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    logic got = 1'b0;
    op_a = a;
    op_b = b;
    op_valid = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (op_ready) got = 1'b1;
      step();
    end
    op_valid = 1'b0;
    if (got) exp_q.push_back({a, b});
    else check("op_push_timeout", 64'(got), 64'd1);
  endtask

  task automatic wait_retired(input int n, input string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (retired_cnt >= 16'(n)) break;
    end
    check(name, 64'(retired_cnt), 64'(n));
    step();
  endtask

  initial begin
    int flips;
    int pulses;
    logic hold_bad;
    logic rv0;
    logic [15:0] iss0;

    rst_n = 1'b0; op_a = '0; op_b = '0; op_valid = 1'b0; enable = 1'b0; rsp_stall = 1'b0;
    req_ready = 1'b1; rsp_valid = 1'b0; rsp_sum = '0;
    @(negedge clk);
    check("rsp_ready_in_reset", 64'(rsp_ready), 64'd0);
    repeat (2) step();
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_idle", 64'(idle), 64'd1);
    check("reset_outputs", {req_valid, drain_done, proto_err, chk_err, acc_total, issued_cnt, retired_cnt}, 64'd0);
    check("reset_ready", {op_ready, rsp_ready}, 64'd3);
    step();

    // Two basic pairs through an ideal adder.
    push(32'd3, 32'd4);
    push(32'd10, 32'd20);
    enable = 1'b1;
    wait_retired(2, "t1_retired");
    @(negedge clk);
    check("t1_issued", 64'(issued_cnt), 64'd2);
    check("t1_acc", 64'(acc_total), 64'd37);
    step();

    // Spurious response with nothing outstanding.
    inject_val = 32'h55;
    inject = 1'b1;
    for (int i = 0; i < 20 && inject; i++) step();
    step();
    @(negedge clk);
    check("t3_inject_consumed", 64'(inject), 64'd0);
    check("t3_proto_err", 64'(proto_err), 64'd1);
    check("t3_acc_unchanged", 64'(acc_total), 64'd37);
    check("t3_retired_unchanged", 64'(retired_cnt), 64'd2);
    step();

    // DATA_W wrap of the sum, then accumulator wrap at 2^34.
    push(32'hFFFF_FFFF, 32'd1);
    wait_retired(3, "t4_retired_a");
    @(negedge clk);
    check("t4_sum_wrap", 64'(acc_total), 64'd37);
    step();
    for (int i = 0; i < 4; i++) push(32'hFFFF_FFFF, 32'd0);
    wait_retired(7, "t4_retired_b");
    @(negedge clk);
    check("t4_acc_wrap", 64'(acc_total), 64'd33);
    step();

    // Response back-pressure limits the issue window to MAX_OUT.
    rsp_stall = 1'b1;
    for (int i = 1; i <= 4; i++) push(32'(i), 32'(i));
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (issued_cnt >= 16'd9) break;
    end
    rv0 = req_valid;
    iss0 = issued_cnt;
    flips = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req_valid !== rv0 || issued_cnt !== iss0) flips++;
    end
    check("t2_issued_window", 64'(issued_cnt), 64'd9);
    check("t2_stable", 64'(flips), 64'd0);
    check("t2_retired_held", 64'(retired_cnt), 64'd7);
    step();
    rsp_stall = 1'b0;
    wait_retired(11, "t2_retired");
    @(negedge clk);
    check("t2_acc", 64'(acc_total), 64'd53);
    check("t2_issued", 64'(issued_cnt), 64'd11);
    step();

    // Drain with a request held pending by the adder.
    acc_en = 1'b0;
    push(32'd5, 32'd6);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_valid) break;
    end
    step();
    enable = 1'b0;
    hold_bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!req_valid || req_a !== 32'd5 || req_b !== 32'd6 || drain_done || idle) hold_bad = 1'b1;
    end
    check("t5_drain_hold", 64'(hold_bad), 64'd0);
    step();
    acc_en = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (drain_done) pulses++;
    end
    check("t5_drain_pulses", 64'(pulses), 64'd1);
    check("t5_idle", 64'(idle), 64'd1);
    check("t5_acc", 64'(acc_total), 64'd64);
    check("t5_retired", 64'(retired_cnt), 64'd12);
    step();

    // Corrupted adder result.
    plus1 = 1'b1;
    enable = 1'b1;
    push(32'd1, 32'd2);
    wait_retired(13, "t6_retired");
    @(negedge clk);
`ifdef LI_ADDER_CHECK_EN
    check("t6_chk_err", 64'(chk_err), 64'd1);
`else
    check("t6_chk_err", 64'(chk_err), 64'd0);
`endif
    check("t6_acc", 64'(acc_total), 64'd68);
    step();
    plus1 = 1'b0;
    enable = 1'b0;
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_reset_clear", {chk_err, proto_err, acc_total, issued_cnt, retired_cnt}, 64'd0);
    check("t6_reset_idle", 64'(idle), 64'd1);
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
